// File: rtl/knight_tour_solver_if.sv
// Command/read-back bundle between the command decoder, the knight tour
// solver and the motion sequencer. With TOUR_STATS_EN defined the bundle also
// carries the backtrack counter.
interface knight_tour_solver_if #(
  parameter int unsigned BOARD_N = 5
);
  localparam int unsigned XW = (BOARD_N > 2) ? $clog2(BOARD_N) : 1;
  localparam int unsigned IW = $clog2(BOARD_N * BOARD_N);

  logic          go;
  logic [XW-1:0] x_start;
  logic [XW-1:0] y_start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [IW-1:0] indx;
  logic [7:0]    move;

`ifdef TOUR_STATS_EN
  logic [31:0]   backtracks;

  modport master (
    output go, x_start, y_start, indx,
    input  busy, done, fail, move, backtracks
  );
  modport slave (
    input  go, x_start, y_start, indx,
    output busy, done, fail, move, backtracks
  );
`else
  modport master (
    output go, x_start, y_start, indx,
    input  busy, done, fail, move
  );
  modport slave (
    input  go, x_start, y_start, indx,
    output busy, done, fail, move
  );
`endif
endinterface

// File: rtl/knight_tour_solver.sv
// Knight's tour search by exhaustive depth-first backtracking on a
// BOARD_N x BOARD_N board. Reports a found tour (done) or a proven failure
// (fail), then serves the one-hot move list through an indexed read port.
// Optional: define TOUR_STATS_EN to add a saturating backtrack counter.
module knight_tour_solver #(
  parameter int unsigned BOARD_N = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  knight_tour_solver_if.slave bus
);
  localparam int unsigned XW     = (BOARD_N > 2) ? $clog2(BOARD_N) : 1;
  localparam int unsigned IW     = $clog2(BOARD_N * BOARD_N);
  localparam int unsigned Cells  = BOARD_N * BOARD_N;
  // Per-level storage is sized to the full index range so every index is in bounds.
  localparam int unsigned Slots  = 1 << IW;
  localparam logic [IW-1:0] LastLvl = IW'(Cells - 2);

  typedef enum logic [2:0] {
    StIdle, StInit, StPossible, StTry, StBackup, StDone, StFail
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0]    sx_q, sy_q;
  logic [XW-1:0]    x_q, y_q;
  logic [IW-1:0]    level_q;
  logic [Cells-1:0] visited_q;
  logic [7:0]       moves_q [Slots];
  logic [7:0]       cand_q  [Slots];

  logic [7:0]         mask;
  logic [7:0]         cand_cur;
  logic [7:0]         pick;
  logic [7:0]         prev_move;
  logic               has_cand;
  logic               start_off;
  logic               go_accept;
  logic [XW-1:0]      nx, ny, bx, by;
  logic signed [XW:0] tx, ty;
  logic [IW-1:0]      tcell;

  // Move k as (dx, dy): k0 (+1,+2) k1 (-1,+2) k2 (-2,+1) k3 (-2,-1)
  //                     k4 (-1,-2) k5 (+1,-2) k6 (+2,-1) k7 (+2,+1)
  function automatic int step_dx(input int k);
    case (k)
      0: return 1;
      1: return -1;
      2: return -2;
      3: return -2;
      4: return -1;
      5: return 1;
      6: return 2;
      default: return 2;
    endcase
  endfunction

  function automatic int step_dy(input int k);
    case (k)
      0: return 2;
      1: return 2;
      2: return 1;
      3: return -1;
      4: return -2;
      5: return -2;
      6: return -1;
      default: return 1;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [7:0] m);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) k = i;
    end
    return k;
  endfunction

  // Negative coordinates and those past the edge (including wrapped ones) are off-board.
  function automatic logic on_board(input logic signed [XW:0] v);
    return !v[XW] && ({1'b0, v[XW-1:0]} < (XW+1)'(BOARD_N));
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [XW-1:0] y);
    return IW'(y) * IW'(BOARD_N) + IW'(x);
  endfunction

  assign cand_cur  = cand_q[level_q];
  assign pick      = cand_cur & (~cand_cur + 8'd1);
  assign has_cand  = |cand_cur;
  assign prev_move = moves_q[level_q - IW'(1)];

  assign nx = XW'(int'(x_q) + step_dx(onehot_idx(pick)));
  assign ny = XW'(int'(y_q) + step_dy(onehot_idx(pick)));
  assign bx = XW'(int'(x_q) - step_dx(onehot_idx(prev_move)));
  assign by = XW'(int'(y_q) - step_dy(onehot_idx(prev_move)));

  assign start_off = ({1'b0, sx_q} >= (XW+1)'(BOARD_N)) || ({1'b0, sy_q} >= (XW+1)'(BOARD_N));
  assign go_accept = bus.go && (state_q == StIdle || state_q == StDone || state_q == StFail);

  // Candidate mask: on-board, unvisited targets from the current square.
  always_comb begin
    mask  = '0;
    tx    = '0;
    ty    = '0;
    tcell = '0;
    for (int k = 0; k < 8; k++) begin
      tx    = (XW+1)'(int'(x_q) + step_dx(k));
      ty    = (XW+1)'(int'(y_q) + step_dy(k));
      tcell = '0;
      if (on_board(tx) && on_board(ty)) begin
        tcell   = cell_idx(tx[XW-1:0], ty[XW-1:0]);
        mask[k] = ~visited_q[tcell];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.fail = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.go) state_d = StInit;
      end
      StDone: begin
        bus.done = 1'b1;
        if (bus.go) state_d = StInit;
      end
      StFail: begin
        bus.fail = 1'b1;
        if (bus.go) state_d = StInit;
      end
      StInit: begin
        bus.busy = 1'b1;
        state_d  = start_off ? StFail : StPossible;
      end
      StPossible: begin
        bus.busy = 1'b1;
        state_d  = StTry;
      end
      StTry: begin
        bus.busy = 1'b1;
        if (!has_cand)               state_d = StBackup;
        else if (level_q == LastLvl) state_d = StDone;
        else                         state_d = StPossible;
      end
      StBackup: begin
        bus.busy = 1'b1;
        state_d  = (level_q == '0) ? StFail : StTry;
      end
      default: state_d = StIdle;
    endcase
  end

  // Search datapath: start latch, position, level, board and per-level move/candidate stacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q      <= '0;
      sy_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      level_q   <= '0;
      visited_q <= '0;
      for (int i = 0; i < int'(Slots); i++) begin
        moves_q[i] <= '0;
        cand_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        StIdle, StDone, StFail: begin
          if (bus.go) begin
            sx_q <= bus.x_start;
            sy_q <= bus.y_start;
          end
        end
        StInit: begin
          x_q       <= sx_q;
          y_q       <= sy_q;
          level_q   <= '0;
          visited_q <= start_off ? '0 : (Cells'(1) << cell_idx(sx_q, sy_q));
        end
        StPossible: begin
          cand_q[level_q] <= mask;
        end
        StTry: begin
          if (has_cand) begin
            // Dropping the taken bit leaves exactly the higher-order retries.
            moves_q[level_q]             <= pick;
            cand_q[level_q]              <= cand_cur & ~pick;
            x_q                          <= nx;
            y_q                          <= ny;
            visited_q[cell_idx(nx, ny)]  <= 1'b1;
            level_q                      <= level_q + IW'(1);
          end
        end
        StBackup: begin
          if (level_q != '0) begin
            visited_q[cell_idx(x_q, y_q)] <= 1'b0;
            x_q                           <= bx;
            y_q                           <= by;
            level_q                       <= level_q - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Move list read port; indices past the last move read as zero.
  always_comb begin
    bus.move = '0;
    if (bus.indx <= LastLvl) bus.move = moves_q[bus.indx];
  end

`ifdef TOUR_STATS_EN
  logic [31:0] backtracks_q;

  // Saturating count of backup steps, cleared when a new search is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           backtracks_q <= '0;
    else if (go_accept)                                   backtracks_q <= '0;
    else if (state_q == StBackup && backtracks_q != '1)   backtracks_q <= backtracks_q + 32'd1;
  end

  assign bus.backtracks = backtracks_q;
`endif

endmodule

// File: doc/knight_tour_solver.md
Name: knight_tour_solver

Overview:
- Parametrised successor to the fixed 5x5 TourLogic.
- Finds a knight's tour on a BOARD_N x BOARD_N board by exhaustive backtracking.
- Reports both success and proven failure, then exposes the move list through an indexed read port.
- Sits between the command decoder (start square, go) and the knight motion sequencer, which reads moves by index after done.

Parameters:
- BOARD_N, 5: board edge length; legal range 3..8.
- XW, $clog2(BOARD_N): coordinate width, minimum 1; derived, do not override.
- IW, $clog2(BOARD_N*BOARD_N): move-index width; derived.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  start request; one-cycle pulse, or level sampled per cycle
- x_start  in  XW  start column, sampled with go
- y_start  in  XW  start row, sampled with go
- busy  out  1  search in progress
- done  out  1  tour found; held until the next accepted go
- fail  out  1  no tour exists from the start square; held until the next accepted go
- indx  in  IW  move-list read index, 0..BOARD_N*BOARD_N-2
- move  out  8  one-hot move at indx, combinational from the move array

Behaviour:
- Reset: all outputs 0, state IDLE, board and move array cleared. Reset mid-search aborts immediately; no partial result is retained.
- Move encoding is one-hot. bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
- Candidate order: low bit to high bit.
- go is accepted only in IDLE, DONE or FAIL. In SEARCH states it is ignored.
- On acceptance:
  - done and fail clear.
  - busy rises on the next edge.
  - x_start and y_start are latched.
- States and transitions:
  - IDLE/DONE/FAIL -> INIT on accepted go.
  - INIT (1 cycle) clears the board and sets move number 0. If x_start or y_start >= BOARD_N, go to FAIL. Otherwise mark the start cell visited and go to POSSIBLE.
  - POSSIBLE (1 cycle) computes the 8-bit mask of on-board, unvisited targets for the current level and stores it per level. Go to TRY.
  - TRY tests the lowest untried candidate bit in the stored mask.
    - If a candidate exists: record it in move[level], mark the target visited, advance position and level, go to POSSIBLE. Reaching level BOARD_N*BOARD_N-1 goes to DONE instead.
    - If no candidate remains: go to BACKUP.
  - BACKUP clears the current cell, decrements level and reverses move[level].
    - If candidates above that move bit remain, go to TRY at that level with them.
    - If level 0 has nothing left, go to FAIL.
- DONE: busy=0, done=1. FAIL: busy=0, fail=1, move array contents are don't-care.
- done and fail are never both 1.
- Read port: move = move_array[indx] when indx <= BOARD_N*BOARD_N-2, else 8'h00. Valid only while done=1.
- Arithmetic: position updates are signed, XW+1 bits wide. Off-board is any coordinate < 0 or >= BOARD_N, and is checked before the board lookup.

Optional Feature:
- Macro TOUR_STATS_EN.
- Defined: adds output backtracks [31:0], which counts BACKUP entries and saturates at 32'hFFFFFFFF. It clears on an accepted go and is held through DONE and FAIL.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- BOARD_N=5, start (2,2), go pulse -> done=1 within 10,000,000 cycles, fail=0. Replaying move[0..23] from (2,2) visits all 25 cells exactly once, with no coordinate leaving 0..4.
- BOARD_N=5, start (0,1) (odd colour) -> fail=1, done=0, busy=0. With TOUR_STATS_EN, backtracks > 0.
- BOARD_N=3, start (0,0) -> fail=1 after the search exhausts. x_start=3 on BOARD_N=3 -> fail=1 two cycles after go, with no SEARCH activity.
- Start (2,2), assert rst_n=0 mid-search, release, go with start (0,0) -> busy restarts from INIT. Completes with done=1 and a valid 24-move tour from (0,0).
- Pulse go with start (1,1) while busy -> ignored; the tour still starts at the original square. After done, go with start (4,4) -> done clears, busy=1 next cycle, new tour valid from (4,4).
- After done, indx=24 and indx=31 -> move=8'h00. indx=0 -> move equals the one-hot of the first step.
